// File: rtl/aes_pkg.sv
// Shared types and arithmetic helpers for the AES key-expansion datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    HOLD,
    FIN
  } state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic int num_rounds(input int nk);
    return nk + 6;
  endfunction

  function automatic int num_words(input int nk);
    return 4 * (num_rounds(nk) + 1);
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: four parallel AES forward S-box lookups.
module aes_sbox_word (
  input  logic [31:0] data,
  output logic [31:0] subst
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign subst[b*8 +: 8] = SBOX[data[b*8 +: 8]];
  end

endmodule

// File: rtl/aes_key_scheduler.sv
// AES key expansion: generates one schedule word per cycle and hands out each
// 128-bit round key through a valid/ready stall.
module aes_key_scheduler
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NK*32-1:0] key_in,
  input  logic            start,
  output logic            busy,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic [127:0]    rk_data,
  output logic [3:0]      rk_idx,
  output logic            done
);

  localparam int NR = num_rounds(NK);
  localparam int NW = num_words(NK);
  localparam int CW = $clog2(NW);
  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_t state, state_next;

  logic [31:0]   win [NK];
  logic [31:0]   acc [3];
  logic [CW-1:0] cnt;
  logic [2:0]    pos;
  logic [7:0]    rcon;

  logic        in_key;
  logic        use_rot;
  logic        use_mid;
  logic [31:0] prev;
  logic [31:0] sbox_in;
  logic [31:0] sbox_out;
  logic [31:0] f_out;
  logic [31:0] word;

  // win[0] is w[i-NK] and win[NK-1] is w[i-1]; the key words simply rotate
  // through the window during the first NK cycles.
  always_comb begin
    in_key  = cnt < CW'(NK);
    use_rot = (pos == 3'd0);
    use_mid = (NK == 8) && (pos == 3'd4);
    prev    = win[NK-1];
    sbox_in = use_rot ? rot_word(prev) : prev;
    f_out   = prev;
    if (use_rot) begin
      f_out = sbox_out ^ {rcon, 24'h0};
    end else if (use_mid) begin
      f_out = sbox_out;
    end
    word = in_key ? win[0] : (win[0] ^ f_out);
  end

  aes_sbox_word u_sbox (
    .data  (sbox_in),
    .subst (sbox_out)
  );

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = GEN;
        end
      end
      GEN: begin
        busy = 1'b1;
        if (cnt[1:0] == 2'd3) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        busy = 1'b1;
        if (rk_valid && rk_ready) begin
          state_next = (rk_idx == LAST_IDX) ? FIN : GEN;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pos      <= '0;
      rcon     <= RCON_INIT;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_idx   <= '0;
      for (int k = 0; k < NK; k++) begin
        win[k] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        acc[k] <= '0;
      end
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NK; k++) begin
              win[k] <= key_in[NK*32-1-32*k -: 32];
            end
            cnt    <= '0;
            pos    <= '0;
            rcon   <= RCON_INIT;
            rk_idx <= '0;
          end
        end
        GEN: begin
          for (int k = 0; k < NK-1; k++) begin
            win[k] <= win[k+1];
          end
          win[NK-1] <= word;
          acc[0]    <= acc[1];
          acc[1]    <= acc[2];
          acc[2]    <= word;
          cnt       <= cnt + 1'b1;
          pos       <= (pos == 3'(NK-1)) ? 3'd0 : pos + 3'd1;
          if (!in_key && use_rot) begin
            rcon <= xtime(rcon);
          end
          // The fourth word of a group completes the round key this cycle.
          if (cnt[1:0] == 2'd3) begin
            rk_valid <= 1'b1;
            rk_data  <= {acc[0], acc[1], acc[2], word};
            rk_idx   <= cnt[CW-1:2];
          end
        end
        HOLD: begin
          if (rk_ready) begin
            rk_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_key_scheduler.md
AES_KEY_SCHEDULER -- requirements
Module: aes_key_scheduler

Interface
REQ-001 The block SHALL have parameter NK, default 4, giving key length in 32-bit words; legal values 4, 6, 8.
REQ-002 The block SHALL have derived constant NR = NK+6 (rounds) and NW = 4*(NR+1) (schedule words).
REQ-003 The block SHALL have these ports, and the clock domain SHALL be: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 key_in  input  NK*32  cipher key; bits [NK*32-1 -: 32] are w[0], then w[1] and so on downward.
REQ-007 start  input  1  request a new schedule; sampled only in IDLE.
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 rk_valid  output  1  rk_data/rk_idx hold a complete round key.
REQ-010 rk_ready  input  1  consumer accepts the round key when rk_valid and rk_ready are both high.
REQ-011 rk_data  output  128  round key; [127:96]=w[4r], [31:0]=w[4r+3].
REQ-012 rk_idx  output  4  round index r, 0..NR.
REQ-013 done  output  1  one-cycle pulse after round key NR is accepted.

Function
REQ-014 The FSM SHALL have states IDLE, GEN, HOLD, FIN.
REQ-015 IDLE with start=1 SHALL register key_in into an NK-word window, clear word counter i and round index, set Rcon=0x01, and go to GEN.
REQ-016 GEN SHALL produce exactly one word w[i] per cycle:
- i<NK: w[i] is key word i.
- otherwise w[i] = w[i-NK] ^ f(w[i-1]).
REQ-017 f SHALL be defined as follows:
- i mod NK == 0: SubWord(RotWord(x)) ^ {Rcon,24'h0}.
- NK==8 and i mod 8 == 4: SubWord(x).
- otherwise: x.
REQ-018 RotWord SHALL be a left byte rotate, {x[23:0],x[31:24]}.
REQ-019 Rcon SHALL advance by GF(2^8) xtime (shift left, XOR 0x1B on carry) after each use.
REQ-020 Each word SHALL shift into the NK-word window and into a 4-word accumulator.
REQ-021 When the accumulator completes (i mod 4 == 3), the next cycle SHALL present it on rk_data with rk_valid=1 and rk_idx=i/4, and the FSM SHALL enter HOLD.
REQ-022 In HOLD, word generation SHALL stall; rk_data, rk_idx and rk_valid SHALL stay stable until the handshake.
REQ-023 On handshake in HOLD, rk_valid SHALL drop the next cycle.
REQ-024 After the HOLD handshake, if rk_idx<NR the FSM SHALL return to GEN; else it SHALL go to FIN.
REQ-025 With rk_ready tied high, round key r SHALL be valid at cycle 4+5r after start acceptance (4 GEN cycles plus 1 HOLD cycle each).
REQ-026 FIN SHALL pulse done for one cycle, drop busy, and return to IDLE.
REQ-027 start while busy SHALL be ignored; key_in changes after acceptance SHALL have no effect.
REQ-028 rk_ready while rk_valid=0 SHALL have no effect.
REQ-029 start in the same cycle as the final handshake SHALL be ignored; start is honoured only in IDLE.

Reset
REQ-030 While rst_n=0 at a clock edge, the block SHALL enter IDLE and set busy=0, rk_valid=0, done=0, rk_data=0, rk_idx=0, i=0, Rcon=0x01, window=0.
REQ-031 Reset mid-schedule SHALL abandon the schedule with no done pulse.
REQ-032 The first start after reset release SHALL behave as from power-up.

Structure
REQ-033 A shared package aes_pkg SHALL hold:
- the state enum;
- the NR/NW derivation function;
- the xtime function;
- the Rcon reset constant 8'h01.
REQ-034 One combinational sub-module aes_sbox_word SHALL be used, performing a 32-bit SubWord via four byte S-boxes.
REQ-035 A single aes_sbox_word instance SHALL be shared by both the RotWord and NK=8 mid-word paths through a mux.

Verification
REQ-036 NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk_idx 1 = a0fafe1788542cb123a339392a6c7605; rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done one cycle after rk_idx 10 is accepted.
REQ-037 NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk_idx 12 = e98ba06f448c773c8ecc720401002202.
REQ-038 NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk_idx 14 = fe4890d1e6188d0b046df344706c631e.
REQ-039 NK=4, rk_ready random 30% duty -> same 11 keys in order, each rk_data stable while stalled, no index skipped or repeated.
REQ-040 Reset pulse at rk_idx 5 HOLD, then start with a new key -> rk_idx restarts at 0 with correct keys; no done before reset.
REQ-041 start pulsed every cycle during a schedule -> no restart; exactly one done per accepted start.
